// File: rtl/lz77_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : lz77_decoder_if
//  Description : Token-in / byte-out handshake bundle for the LZ77 decoder.
//                master = token source + byte sink side (upstream/downstream)
//                slave  = the decoder itself
//  Signals     : tok_valid/tok_ready/tok_position/tok_length/tok_symbol/
//                tok_last (token stream), out_valid/out_ready/out_data/
//                out_last (byte stream), dist_err (sticky status)
//  Revision    : 1.0 - initial release
// ============================================================================
interface lz77_decoder_if #(
   parameter int DATA_WIDTH           = 8,
   parameter int DICTIONARY_DEPTH_LOG = 9,
   parameter int CNT_WIDTH            = 7
);
   logic                          tok_valid;
   logic                          tok_ready;
   logic [DICTIONARY_DEPTH_LOG:0] tok_position;
   logic [CNT_WIDTH-1:0]          tok_length;
   logic [DATA_WIDTH-1:0]         tok_symbol;
   logic                          tok_last;
   logic                          out_valid;
   logic                          out_ready;
   logic [DATA_WIDTH-1:0]         out_data;
   logic                          out_last;
   logic                          dist_err;

   modport master (
      output tok_valid, tok_position, tok_length, tok_symbol, tok_last, out_ready,
      input  tok_ready, out_valid, out_data, out_last, dist_err
   );

   modport slave (
      input  tok_valid, tok_position, tok_length, tok_symbol, tok_last, out_ready,
      output tok_ready, out_valid, out_data, out_last, dist_err
   );
endinterface
`default_nettype wire

// File: rtl/lz77_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : lz77_decoder
//  Description : LZ77 token decoder. Each {distance, length, symbol} token
//                expands into `length` bytes copied from the history window
//                followed by the literal symbol. Keeps its own history of the
//                last DICTIONARY_DEPTH output bytes.
//  Ports       : clk   - clock, rising edge
//                rst_n - asynchronous active-low reset
//                bus   - lz77_decoder_if.slave (token in, byte out, dist_err)
//  Revision    : 1.0 - initial release
// ============================================================================
module lz77_decoder #(
   parameter int DATA_WIDTH           = 8,
   parameter int DICTIONARY_DEPTH     = 512,
   parameter int DICTIONARY_DEPTH_LOG = 9,
   parameter int CNT_WIDTH            = 7
) (
   input  logic          clk,
   input  logic          rst_n,
   lz77_decoder_if.slave bus
);
   localparam int PTR_W  = DICTIONARY_DEPTH_LOG;
   localparam int DIST_W = DICTIONARY_DEPTH_LOG + 1;
   localparam logic [DIST_W-1:0] FILL_MAX = DIST_W'(DICTIONARY_DEPTH);

   generate
      if (DICTIONARY_DEPTH != (1 << DICTIONARY_DEPTH_LOG)) begin : g_depth_check
         $fatal(1, "lz77_decoder: DICTIONARY_DEPTH must equal 2**DICTIONARY_DEPTH_LOG");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_COPY = 2'd1,
      S_LIT  = 2'd2
   } state_t;

   state_t                state, state_next;

   logic                  armed;        // holds tok_ready low until the first clock after reset
   logic [PTR_W-1:0]      wr_ptr, rd_ptr;
   logic [DIST_W-1:0]     fill;
   logic [CNT_WIDTH-1:0]  cnt;
   logic [DATA_WIDTH-1:0] sym_q;
   logic                  last_q;
   logic                  bad_q;        // current token has an illegal distance
   logic                  out_valid_q, out_last_q, dist_err_q;
   logic [DATA_WIDTH-1:0] out_data_q;

   logic [DATA_WIDTH-1:0] hist [DICTIONARY_DEPTH];

   logic                  adv, accept, emit, emit_last, tok_ready_c;
   logic [DATA_WIDTH-1:0] emit_data, hist_rd;
   logic                  xfer_last, dist_bad;
   logic [DIST_W-1:0]     fill_base;

   // Output register may take a new byte when it is empty or being drained.
   assign adv = !out_valid_q || bus.out_ready;

   // Combinational history read: every write from earlier cycles is visible,
   // so an overlapping copy (D < L, D = 1) reads the bytes it just produced.
   // With D = DICTIONARY_DEPTH the read and write address coincide; the read
   // returns the old (oldest) byte, which is exactly what is rewritten.
   assign hist_rd = hist[rd_ptr];

   // The last byte of a block leaving the output register starts a new block.
   // The token accepted in that same cycle must already see an empty window.
   assign xfer_last = out_valid_q && bus.out_ready && out_last_q;
   assign fill_base = xfer_last ? '0 : fill;
   assign dist_bad  = (bus.tok_position == '0) || (bus.tok_position > fill_base);

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_next;
   end

   // ------------------------------------------------------------------------
   // FSM: next state and per-cycle controls
   // ------------------------------------------------------------------------
   always_comb begin
      state_next  = state;
      tok_ready_c = 1'b0;
      accept      = 1'b0;
      emit        = 1'b0;
      emit_data   = '0;
      emit_last   = 1'b0;
      case (state)
         S_IDLE: begin
            tok_ready_c = armed;
            if (bus.tok_valid && armed) begin
               accept     = 1'b1;
               state_next = (bus.tok_length == '0) ? S_LIT : S_COPY;
            end
         end
         S_COPY: begin
            if (adv) begin
               emit      = 1'b1;
               emit_data = bad_q ? '0 : hist_rd;
               if (cnt == CNT_WIDTH'(1)) state_next = S_LIT;
            end
         end
         S_LIT: begin
            if (adv) begin
               emit       = 1'b1;
               emit_data  = sym_q;
               emit_last  = last_q;
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath: pointers, counters, token latches and output register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed       <= 1'b0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fill        <= '0;
         cnt         <= '0;
         sym_q       <= '0;
         last_q      <= 1'b0;
         bad_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         dist_err_q  <= 1'b0;
      end else begin
         armed <= 1'b1;

         if (accept) begin
            sym_q  <= bus.tok_symbol;
            last_q <= bus.tok_last;
            cnt    <= bus.tok_length;
            // Low bits only: D = DICTIONARY_DEPTH wraps to rd_ptr = wr_ptr.
            rd_ptr <= wr_ptr - bus.tok_position[PTR_W-1:0];
            bad_q  <= dist_bad;
            if (dist_bad && (bus.tok_length != '0)) dist_err_q <= 1'b1;
         end

         if ((state == S_COPY) && emit) begin
            cnt    <= cnt - CNT_WIDTH'(1);
            rd_ptr <= rd_ptr + PTR_W'(1);
         end

         if (emit) wr_ptr <= wr_ptr + PTR_W'(1);

         if (emit && (fill_base != FILL_MAX)) fill <= fill_base + DIST_W'(1);
         else                                 fill <= fill_base;

         if (adv) begin
            out_valid_q <= emit;
            out_last_q  <= emit && emit_last;
            if (emit) out_data_q <= emit_data;
         end
      end
   end

   // History RAM: not cleared by reset.
   always_ff @(posedge clk) begin
      if (emit) hist[wr_ptr] <= emit_data;
   end

   assign bus.tok_ready = tok_ready_c;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_last  = out_last_q;
   assign bus.dist_err  = dist_err_q;

endmodule
`default_nettype wire

// File: tb/tb_lz77_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lz77_decoder
//  Description : Directed self-checking bench for lz77_decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lz77_decoder;
   localparam int DW = 8;
   localparam int DD = 512;
   localparam int DL = 9;
   localparam int CW = 7;

   logic clk;
   logic rst_n;

   lz77_decoder_if #(.DATA_WIDTH(DW), .DICTIONARY_DEPTH_LOG(DL), .CNT_WIDTH(CW)) bus ();

   lz77_decoder #(
      .DATA_WIDTH(DW), .DICTIONARY_DEPTH(DD),
      .DICTIONARY_DEPTH_LOG(DL), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   int vectors = 0;
   int miscompares = 0;

   logic [8:0]    q[$];      // captured {out_last, out_data}
   int            qc[$];     // cycle stamp of each captured byte
   int            cyc = 0;
   bit            bp_mode = 0;
   bit            stalled = 0;
   logic [DW-1:0] held;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // out_ready driver: constant 1, or toggling every cycle in backpressure mode
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (bp_mode) bus.out_ready = ~bus.out_ready;
         else         bus.out_ready = 1'b1;
      end
   end

   // Byte monitor: mid-cycle sampling; a byte seen valid&ready here transfers
   // on the next rising edge. Also checks that a stalled byte holds.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            stalled = 0;
         end else begin
            if (stalled) begin
               check("hold_valid", 32'(bus.out_valid), 32'd1);
               check("hold_data", 32'(bus.out_data), 32'(held));
            end
            if (bus.out_valid && bus.out_ready) begin
               q.push_back({bus.out_last, bus.out_data});
               qc.push_back(cyc);
            end
            stalled = bus.out_valid && !bus.out_ready;
            held    = bus.out_data;
         end
      end
   end

   task automatic send(input logic [DL:0] d, input logic [CW-1:0] l,
                       input logic [DW-1:0] s, input bit last);
      int t;
      t = 0;
      bus.tok_position = d;
      bus.tok_length   = l;
      bus.tok_symbol   = s;
      bus.tok_last     = last;
      bus.tok_valid    = 1'b1;
      while (!bus.tok_ready && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (t >= 500) check("tok_accept_timeout", 32'(t), 32'd0);
      @(posedge clk);
      #1;
      bus.tok_valid = 1'b0;
   endtask

   task automatic wait_bytes(input string tag, input int n);
      int t;
      t = 0;
      while (q.size() < n && t < 3000) begin
         @(negedge clk);
         t++;
      end
      check({tag, "_count"}, 32'(q.size()), 32'(n));
   endtask

   task automatic expect_byte(input string tag, input int idx, input logic [DW-1:0] d, input bit l);
      logic [8:0] got;
      if (idx < q.size()) got = q[idx];
      else                got = 'x;
      check($sformatf("%s[%0d]", tag, idx), 32'(got), 32'({l, d}));
   endtask

   initial begin
      rst_n            = 1'b0;
      bus.tok_valid    = 1'b0;
      bus.tok_position = '0;
      bus.tok_length   = '0;
      bus.tok_symbol   = '0;
      bus.tok_last     = 1'b0;

      // ---------------- reset state ----------------
      repeat (2) @(negedge clk);
      check("rst_tok_ready", 32'(bus.tok_ready), 32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_data",  32'(bus.out_data),  32'd0);
      check("rst_out_last",  32'(bus.out_last),  32'd0);
      check("rst_dist_err",  32'(bus.dist_err),  32'd0);
      rst_n = 1'b1;
      #1;
      check("rel_tok_ready_low", 32'(bus.tok_ready), 32'd0);
      @(posedge clk);
      #1;
      check("rel_tok_ready_high", 32'(bus.tok_ready), 32'd1);

      // ---------------- literals only ----------------
      q.delete(); qc.delete();
      send(10'd0, 7'd0, "a", 1'b0);
      send(10'd0, 7'd0, "b", 1'b0);
      send(10'd0, 7'd0, "c", 1'b1);
      wait_bytes("lit", 3);
      expect_byte("lit", 0, "a", 1'b0);
      expect_byte("lit", 1, "b", 1'b0);
      expect_byte("lit", 2, "c", 1'b1);
      check("lit_dist_err", 32'(bus.dist_err), 32'd0);

      // ---------------- back-reference ----------------
      q.delete(); qc.delete();
      send(10'd0, 7'd0, "a", 1'b0);
      send(10'd0, 7'd0, "b", 1'b0);
      send(10'd0, 7'd0, "c", 1'b0);
      send(10'd0, 7'd0, "d", 1'b0);
      send(10'd4, 7'd4, "e", 1'b1);
      wait_bytes("bref", 9);
      expect_byte("bref", 0, "a", 1'b0);
      expect_byte("bref", 1, "b", 1'b0);
      expect_byte("bref", 2, "c", 1'b0);
      expect_byte("bref", 3, "d", 1'b0);
      expect_byte("bref", 4, "a", 1'b0);
      expect_byte("bref", 5, "b", 1'b0);
      expect_byte("bref", 6, "c", 1'b0);
      expect_byte("bref", 7, "d", 1'b0);
      expect_byte("bref", 8, "e", 1'b1);
      check("bref_consecutive", 32'(qc[8] - qc[4]), 32'd4);
      check("bref_dist_err", 32'(bus.dist_err), 32'd0);

      // ---------------- overlap run ----------------
      q.delete(); qc.delete();
      send(10'd0, 7'd0, "x", 1'b0);
      send(10'd1, 7'd10, "y", 1'b1);
      wait_bytes("ovl", 12);
      for (int i = 0; i < 11; i++) expect_byte("ovl", i, "x", 1'b0);
      expect_byte("ovl", 11, "y", 1'b1);
      check("ovl_consecutive", 32'(qc[11] - qc[1]), 32'd10);

      // ---------------- backpressure ----------------
      q.delete(); qc.delete();
      bp_mode = 1;
      send(10'd0, 7'd0, "x", 1'b0);
      wait_bytes("bp_first", 1);
      send(10'd1, 7'd10, "y", 1'b1);
      begin
         int t;
         t = 0;
         while (q.size() < 11 && t < 500) begin
            check("bp_tok_ready", 32'(bus.tok_ready), 32'd0);
            @(negedge clk);
            t++;
         end
      end
      wait_bytes("bp", 12);
      for (int i = 0; i < 11; i++) expect_byte("bp", i, "x", 1'b0);
      expect_byte("bp", 11, "y", 1'b1);
      bp_mode = 0;
      repeat (2) @(posedge clk);
      #1;

      // ---------------- wrap and full window ----------------
      q.delete(); qc.delete();
      for (int i = 0; i < 600; i++) send(10'd0, 7'd0, 8'(i % 256), 1'b0);
      send(10'd512, 7'd3, 8'hAA, 1'b1);
      wait_bytes("wrap", 604);
      expect_byte("wrap", 599, 8'h57, 1'b0);
      expect_byte("wrap", 600, 8'h58, 1'b0);
      expect_byte("wrap", 601, 8'h59, 1'b0);
      expect_byte("wrap", 602, 8'h5A, 1'b0);
      expect_byte("wrap", 603, 8'hAA, 1'b1);
      check("wrap_dist_err", 32'(bus.dist_err), 32'd0);

      // ---------------- illegal distance ----------------
      q.delete(); qc.delete();
      send(10'd0, 7'd0, "p", 1'b0);
      send(10'd0, 7'd0, "q", 1'b0);
      send(10'd5, 7'd2, "z", 1'b1);
      wait_bytes("err", 5);
      expect_byte("err", 0, "p", 1'b0);
      expect_byte("err", 1, "q", 1'b0);
      expect_byte("err", 2, 8'h00, 1'b0);
      expect_byte("err", 3, 8'h00, 1'b0);
      expect_byte("err", 4, "z", 1'b1);
      check("err_dist_err", 32'(bus.dist_err), 32'd1);
      send(10'd0, 7'd0, "s", 1'b1);
      wait_bytes("err_sticky", 6);
      expect_byte("err_sticky", 5, "s", 1'b1);
      check("err_sticky_flag", 32'(bus.dist_err), 32'd1);

      // ---------------- reset mid-copy ----------------
      q.delete(); qc.delete();
      send(10'd0, 7'd0, "k", 1'b0);
      send(10'd1, 7'd20, "m", 1'b0);
      repeat (5) @(posedge clk);
      #1;
      check("mid_out_valid", 32'(bus.out_valid), 32'd1);
      check("mid_out_data", 32'(bus.out_data), 32'("k"));
      #1;
      rst_n = 1'b0;
      #1;
      check("arst_tok_ready", 32'(bus.tok_ready), 32'd0);
      check("arst_out_valid", 32'(bus.out_valid), 32'd0);
      check("arst_out_data",  32'(bus.out_data),  32'd0);
      check("arst_out_last",  32'(bus.out_last),  32'd0);
      check("arst_dist_err",  32'(bus.dist_err),  32'd0);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      q.delete(); qc.delete();
      @(posedge clk);
      #1;
      check("arst_tok_ready_back", 32'(bus.tok_ready), 32'd1);
      send(10'd0, 7'd0, "r", 1'b1);
      wait_bytes("post_rst", 1);
      expect_byte("post_rst", 0, "r", 1'b1);
      repeat (3) @(posedge clk);
      check("post_rst_idle", 32'(q.size()), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
`default_nettype wire
